// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared helpers and parameter checks for the arbiter input buffer
`ifndef ARB_PKG_MACROS
`define ARB_PKG_MACROS
`define ARB_CHECK_POW2(blk, val) \
   if (((val) < 2) || (((val) & ((val) - 1)) != 0)) begin : blk \
      $error("Depth must be a power of two and at least 2"); \
   end
`define ARB_CHECK_RANGE(blk, val, lo, hi) \
   if (((val) < (lo)) || ((val) > (hi))) begin : blk \
      $error("AFull must lie between 1 and Depth"); \
   end
`endif

package arb_pkg;

   // Never returns 0 so a degenerate parameter still yields a legal vector width.
   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_vr.sv
// rtl/fifo_vr.sv - single-channel valid/ready FIFO with occupancy and almost-full status
import arb_pkg::*;

module fifo_vr #(
   parameter  int Width = 32,
   parameter  int Depth = 4,
   parameter  int AFull = 3,
   localparam int PtrW  = clog2_safe(Depth),
   localparam int CntW  = clog2_safe(Depth + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_valid,
   input  logic [Width-1:0] wr_data,
   output logic             wr_ready,
   output logic             rd_valid,
   output logic [Width-1:0] rd_data,
   input  logic             rd_ready,
   output logic [CntW-1:0]  count,
   output logic             almost_full
);

   `ARB_CHECK_POW2(g_chk_depth, Depth)
   `ARB_CHECK_RANGE(g_chk_afull, AFull, 1, Depth)

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full;
   logic             wr_fire;
   logic             rd_fire;

   // Ready is a function of registered occupancy only: no write-through when full.
   assign full        = (count_q == CntW'(Depth));
   assign wr_ready    = !full && !rst;
   assign rd_valid    = (count_q != '0);
   assign rd_data     = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign almost_full = (count_q >= CntW'(AFull));

   assign wr_fire = wr_valid && wr_ready;
   assign rd_fire = rd_valid && rd_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (rd_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (wr_fire && !rd_fire)      count_d = count_q + CntW'(1);
         else if (rd_fire && !wr_fire) count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage holds no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_fire && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/arbiter_input_buffer.sv
// rtl/arbiter_input_buffer.sv - per-port elastic buffers feeding the round-robin arbiter lanes
import arb_pkg::*;

module arbiter_input_buffer #(
   parameter  int Port  = 2,
   parameter  int Width = 32,
   parameter  int Depth = 4,
   parameter  int AFull = 3,
   localparam int CntW  = clog2_safe(Depth + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [Port-1:0]            flush,
   input  logic [Port-1:0]            wr_valid,
   input  logic [Port-1:0][Width-1:0] wr_data,
   output logic [Port-1:0]            wr_ready,
   output logic [Port-1:0]            rd_valid,
   output logic [Port-1:0][Width-1:0] rd_data,
   input  logic [Port-1:0]            rd_ready,
   output logic [Port-1:0][CntW-1:0]  count,
   output logic [Port-1:0]            almost_full
);

   for (genvar p = 0; p < Port; p++) begin : g_port
      fifo_vr #(
         .Width(Width),
         .Depth(Depth),
         .AFull(AFull)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush[p]),
         .wr_valid   (wr_valid[p]),
         .wr_data    (wr_data[p]),
         .wr_ready   (wr_ready[p]),
         .rd_valid   (rd_valid[p]),
         .rd_data    (rd_data[p]),
         .rd_ready   (rd_ready[p]),
         .count      (count[p]),
         .almost_full(almost_full[p])
      );
   end

endmodule

// File: tb/tb_arbiter_input_buffer.sv
// tb/tb_arbiter_input_buffer.sv - randomized scoreboard bench for arbiter_input_buffer
module tb_arbiter_input_buffer;

   localparam int P  = 2;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int AF = 3;
   localparam int CW = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [P-1:0]         flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full;
   logic [P-1:0][W-1:0]  wr_data, rd_data;
   logic [P-1:0][CW-1:0] count;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [W-1:0] sb [P][$];

   arbiter_input_buffer #(.Port(P), .Width(W), .Depth(D), .AFull(AF)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_ready   (rd_ready),
      .count      (count),
      .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per port, updated from the handshake rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < P; p++) sb[p].delete();
      end else begin
         for (int p = 0; p < P; p++) begin
            if (flush[p]) begin
               sb[p].delete();
            end else begin
               int  n;
               bit  do_wr;
               bit  do_rd;
               n     = sb[p].size();
               do_wr = wr_valid[p] && (n < D);
               do_rd = rd_ready[p] && (n > 0);
               if (do_rd) void'(sb[p].pop_front());
               if (do_wr) sb[p].push_back(wr_data[p]);
            end
         end
      end
   end

   // Monitor compares DUT outputs against the model away from the active edge.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         for (int p = 0; p < P; p++) begin
            int n;
            n = sb[p].size();
            chk($sformatf("count[%0d]", p), 64'(count[p]), 64'(n));
            chk($sformatf("wr_ready[%0d]", p), 64'(wr_ready[p]), 64'(n < D));
            chk($sformatf("rd_valid[%0d]", p), 64'(rd_valid[p]), 64'(n > 0));
            chk($sformatf("almost_full[%0d]", p), 64'(almost_full[p]), 64'(n >= AF));
            if (n > 0) chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(sb[p][0]));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush    = '0;
      wr_valid = '0;
      rd_ready = '0;
      wr_data  = '0;
   endtask

   task automatic drain();
      wr_valid = '0;
      rd_ready = '1;
      step(D + 2);
      rd_ready = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #2;
      chk("reset_wr_ready", 64'(wr_ready), 64'(0));
      chk("reset_rd_valid", 64'(rd_valid), 64'(0));
      chk("reset_count", 64'(count), 64'(0));
      chk("reset_almost_full", 64'(almost_full), 64'(0));
      step(2);
      rst    = 1'b0;
      mon_en = 1'b1;
      #2;
      chk("wr_ready_after_release", 64'(wr_ready), 64'(2'b11));

      // Fill port 0 to full with back-pressure held
      for (int i = 0; i < 4; i++) begin
         wr_valid[0] = 1'b1;
         wr_data[0]  = 32'hA + 32'(i);
         step(1);
         if (i == 2) chk("afull_at_3", 64'(almost_full[0]), 64'(1));
      end
      wr_valid[0] = 1'b0;
      chk("full_count", 64'(count[0]), 64'(4));
      chk("full_wr_ready", 64'(wr_ready[0]), 64'(0));
      rd_ready[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("order_read", 64'(rd_data[0]), 64'(32'hA + 32'(i)));
         step(1);
      end
      rd_ready[0] = 1'b0;
      chk("drained_count", 64'(count[0]), 64'(0));

      // Streaming at a steady level of two
      wr_valid[0] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wr_data[0] = 32'd100 + 32'(i);
         step(1);
      end
      rd_ready[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_data[0] = 32'd102 + 32'(i);
         chk("stream_data", 64'(rd_data[0]), 64'(32'd100 + 32'(i)));
         step(1);
      end
      chk("stream_count", 64'(count[0]), 64'(2));
      drain();

      // Full with simultaneous read: write rejected, then accepted
      wr_valid[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_data[0] = 32'd200 + 32'(i);
         step(1);
      end
      wr_data[0]  = 32'h300;
      rd_ready[0] = 1'b1;
      chk("full_read_wr_ready", 64'(wr_ready[0]), 64'(0));
      step(1);
      chk("full_read_count", 64'(count[0]), 64'(3));
      chk("full_read_ready_back", 64'(wr_ready[0]), 64'(1));
      rd_ready[0] = 1'b0;
      step(1);
      wr_valid[0] = 1'b0;
      chk("full_read_refill", 64'(count[0]), 64'(4));
      drain();

      // Flush on port 1 while writing, port 0 keeps streaming
      wr_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wr_data[0] = 32'h900 + 32'(i);
         wr_data[1] = 32'h10 + 32'(i);
         step(1);
      end
      flush[1]   = 1'b1;
      wr_data[1] = 32'h55;
      wr_data[0] = 32'h999;
      step(1);
      flush       = '0;
      wr_valid    = '0;
      chk("flush_count1", 64'(count[1]), 64'(0));
      chk("flush_rd_valid1", 64'(rd_valid[1]), 64'(0));
      chk("flush_port0_count", 64'(count[0]), 64'(4));
      drain();

      // Asynchronous reset mid-cycle with both ports half full
      wr_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         wr_data[0] = 32'h40 + 32'(i);
         wr_data[1] = 32'h50 + 32'(i);
         step(1);
      end
      wr_valid = '0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rd_valid", 64'(rd_valid), 64'(0));
      chk("async_count", 64'(count), 64'(0));
      chk("async_wr_ready", 64'(wr_ready), 64'(0));
      step(2);
      rst = 1'b0;
      wr_valid[0] = 1'b1;
      wr_data[0]  = 32'h77;
      step(1);
      wr_valid[0] = 1'b0;
      chk("post_reset_valid", 64'(rd_valid[0]), 64'(1));
      chk("post_reset_data", 64'(rd_data[0]), 64'(32'h77));
      drain();

      // Randomized traffic on both ports
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < P; p++) begin
            wr_valid[p] = 1'($urandom_range(0, 2) != 0);
            rd_ready[p] = 1'($urandom_range(0, 2) == 0) || (c > 300 && $urandom_range(0, 1) == 1);
            flush[p]    = 1'($urandom_range(0, 31) == 0);
            wr_data[p]  = $urandom;
         end
         step(1);
      end
      flush = '0;
      drain();
      chk("final_count", 64'(count), 64'(0));

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
